multicycle_controller: RTL and testbench

//  Parametrised multi-cycle control FSM for the RV32I core; successor to the single-cycle opcode decoder.

---
 rtl/multicycle_controller.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes, wait timeouts and instret.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes in DECODE fault instead of retiring as a NOP.
module multicycle_controller #(
    parameter int IMEM_WAIT_MAX = 15,
    parameter int DMEM_WAIT_MAX = 15,
    parameter int INSTRET_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           Opcode,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 ALUSrc,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 Jump,
    output logic                 Jalr,
    output logic                 Branch,
    output logic                 Lui,
    output logic                 Auipc,
    output logic [1:0]           ALUOp,
    output logic [2:0]           state_o,
    output logic                 fault,
    output logic [INSTRET_W-1:0] instret
);
    localparam int WMAX = (IMEM_WAIT_MAX > DMEM_WAIT_MAX) ? IMEM_WAIT_MAX : DMEM_WAIT_MAX;
    localparam int CW   = $clog2(WMAX + 2);
    localparam logic [CW-1:0] IMAX = CW'(IMEM_WAIT_MAX);
    localparam logic [CW-1:0] DMAX = CW'(DMEM_WAIT_MAX);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [6:0]             op_q, op_d;
    logic [CW-1:0]          wait_q, wait_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   retire;
    logic                   lvl_en;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BR, OP_IMM,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    endfunction

    logic is_r, is_lw, is_sw, is_br, is_imm, is_jal, is_jalr, is_lui, is_auipc;
    assign is_r     = (op_q == OP_R);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_br    = (op_q == OP_BR);
    assign is_imm   = (op_q == OP_IMM);
    assign is_jal   = (op_q == OP_JAL);
    assign is_jalr  = (op_q == OP_JALR);
    assign is_lui   = (op_q == OP_LUI);
    assign is_auipc = (op_q == OP_AUIPC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wait_d   = wait_q;
        retire   = 1'b0;
        lvl_en   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == IMAX) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                op_d = Opcode;
                if (legal_op(Opcode)) begin
                    state_d = S_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_FAULT;
`else
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                lvl_en = 1'b1;
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_br) begin
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                lvl_en   = 1'b1;
                dmem_req = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (dmem_ack) begin
                    if (is_sw) begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == DMAX) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                lvl_en   = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = is_lw;
                PCWrite  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_FAULT: ;
            default: state_d = S_FAULT;
        endcase
        if (state_d != state_q) wait_d = '0;
        // state is already FETCH under reset; only the fetch request/strobe need masking
        if (!reset) begin
            imem_req = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    assign instret_d = instret_q + INSTRET_W'(retire);

    always_comb begin
        ALUSrc = 1'b0;
        Jump   = 1'b0;
        Jalr   = 1'b0;
        Branch = 1'b0;
        Lui    = 1'b0;
        Auipc  = 1'b0;
        ALUOp  = 2'b00;
        if (lvl_en) begin
            ALUSrc = is_lw | is_sw | is_imm | is_jal | is_jalr | is_lui | is_auipc;
            Jump   = is_jal | is_jalr;
            Jalr   = is_jalr;
            Branch = is_br;
            Lui    = is_lui;
            Auipc  = is_auipc;
            if (is_br)       ALUOp = 2'b01;
            else if (is_r)   ALUOp = 2'b10;
            else if (is_imm) ALUOp = 2'b11;
        end
    end

    assign state_o = state_q;
    assign fault   = (state_q == S_FAULT);
    assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction expected traces built from the control rules.
module tb_multicycle_controller;
    logic       clk, reset;
    logic [6:0] Opcode;
    logic       imem_ack, dmem_ack;
    logic       imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite;
    logic       MemRead, MemWrite, Jump, Jalr, Branch, Lui, Auipc, fault;
    logic [1:0] ALUOp;
    logic [2:0] state_o;
    logic [3:0] instret;

    multicycle_controller #(.IMEM_WAIT_MAX(15), .DMEM_WAIT_MAX(15), .INSTRET_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Jump(Jump), .Jalr(Jalr), .Branch(Branch), .Lui(Lui),
        .Auipc(Auipc), .ALUOp(ALUOp), .state_o(state_o), .fault(fault), .instret(instret)
    );

    typedef struct packed {
        logic       imem_req, dmem_req, irw, pcw, alusrc, memtoreg, regw, memr, memw;
        logic       jump, jalr, branch, lui, auipc;
        logic [1:0] aluop;
        logic [2:0] st;
        logic       flt;
    } outs_t;

    outs_t obs;
    assign obs = {imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead,
                  MemWrite, Jump, Jalr, Branch, Lui, Auipc, ALUOp, state_o, fault};

    localparam int C_ILL = 0, C_R = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_IMM = 5;
    localparam int C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUIPC = 9;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] icnt   = '0;
    logic [6:0] optab [11] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'h00, 7'h7F};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cls(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b1100011: return C_BR;
            7'b0010011: return C_IMM;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    // level controls seen in EXEC/MEM/WB for an instruction class
    function automatic outs_t lvl(input int c, input logic [2:0] st);
        outs_t o = '0;
        o.st     = st;
        o.alusrc = !(c == C_R || c == C_BR);
        o.jump   = (c == C_JAL || c == C_JALR);
        o.jalr   = (c == C_JALR);
        o.branch = (c == C_BR);
        o.lui    = (c == C_LUI);
        o.auipc  = (c == C_AUIPC);
        o.aluop  = (c == C_BR) ? 2'b01 : (c == C_R) ? 2'b10 : (c == C_IMM) ? 2'b11 : 2'b00;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    // Entered on a negedge: drive, check, then advance to the next negedge.
    task automatic step(input logic ia, input logic da, input logic [6:0] opc, input outs_t e,
                        input bit ret, input bit abort, input string tag);
        imem_ack = ia;
        dmem_ack = da;
        Opcode   = opc;
        #1;
        chk({tag, "_outs"}, 32'(obs), 32'(e));
        chk({tag, "_instret"}, 32'(instret), 32'(icnt));
        if (abort) begin
            #1 reset = 1'b0;
            imem_ack = 1'b1;
            #1;
            chk("async_rst_outs", 32'(obs), 32'd0);
            chk("async_rst_instret", 32'(instret), 32'd0);
            icnt = '0;
            @(negedge clk);
            chk("rst_hold_outs", 32'(obs), 32'd0);
            reset = 1'b1;
        end else begin
            if (ret) icnt = icnt + 4'd1;
            @(negedge clk);
        end
    endtask

    task automatic rst_hold();
        reset    = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #1;
        chk("rst_outs", 32'(obs), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        @(negedge clk);
        #1 chk("rst_outs2", 32'(obs), 32'd0);
        @(negedge clk);
        icnt  = '0;
        reset = 1'b1;
    endtask

    task automatic do_fault();
        outs_t e = '0;
        e.st  = 3'd5;
        e.flt = 1'b1;
        repeat (3) step(rbit(), rbit(), rop(), e, 0, 0, "fault");
        rst_hold();
    endtask

    task automatic run_instr(input logic [6:0] op, input int di, input int dd, input bit abort_wb);
        outs_t e;
        int    c = cls(op);
        for (int k = 0; k < 16; k++) begin
            e          = '0;
            e.imem_req = 1'b1;
            e.irw      = (k == di);
            step(k == di, rbit(), rop(), e, 0, 0, "fetch");
            if (k == di) break;
            if (k == 15) begin
                do_fault();
                return;
            end
        end
        e    = '0;
        e.st = 3'd1;
        if (c == C_ILL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            step(rbit(), rbit(), op, e, 0, 0, "decode_ill");
            do_fault();
`else
            e.pcw = 1'b1;
            step(rbit(), rbit(), op, e, 1, 0, "decode_nop");
`endif
            return;
        end
        step(rbit(), rbit(), op, e, 0, 0, "decode");
        e = lvl(c, 3'd2);
        if (c == C_BR) begin
            e.pcw = 1'b1;
            step(rbit(), rbit(), rop(), e, 1, 0, "exec_br");
            return;
        end
        step(rbit(), rbit(), rop(), e, 0, 0, "exec");
        if (c == C_LW || c == C_SW) begin
            for (int m = 0; m < 16; m++) begin
                e          = lvl(c, 3'd3);
                e.dmem_req = 1'b1;
                e.memr     = (c == C_LW);
                e.memw     = (c == C_SW);
                e.pcw      = (m == dd && c == C_SW);
                step(rbit(), m == dd, rop(), e, m == dd && c == C_SW, 0, "mem");
                if (m == dd) break;
                if (m == 15) begin
                    do_fault();
                    return;
                end
            end
            if (c == C_SW) return;
        end
        e          = lvl(c, 3'd4);
        e.regw     = 1'b1;
        e.memtoreg = (c == C_LW);
        e.pcw      = 1'b1;
        step(rbit(), rbit(), rop(), e, 1, abort_wb, "wb");
    endtask

    function automatic int rdelay();
        int r = int'($urandom_range(9, 0));
        return (r < 7) ? (r % 4) : (r == 7) ? 15 : 16;
    endfunction

    initial begin
        reset    = 1'b0;
        Opcode   = '0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        rst_hold();
        run_instr(7'b0110011, 0, 0, 0);
        run_instr(7'b0000011, 0, 3, 0);
        run_instr(7'b0100011, 2, 0, 0);
        run_instr(7'b0110011, 16, 0, 0);
        run_instr(7'b0010011, 15, 0, 0);
        run_instr(7'b0000011, 1, 16, 0);
        run_instr(7'b0000000, 0, 0, 0);
        run_instr(7'b0110111, 0, 0, 1);
        for (int n = 0; n < 300; n++)
            run_instr(optab[$urandom_range(10, 0)], rdelay(), rdelay(), ($urandom_range(19, 0) == 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
